// File: rtl/top_pkg.sv
// -----------------------------------------------------------------------------
// top_pkg
// Shared constants for the loadable counter / barrel shifter display design:
//   CNT_W      - width of the shift-amount counter (4)
//   DATA_W     - width of the data word being shifted (16)
//   SEG_BLANK  - active-low segment pattern for a dark digit
//   SEG_LUT    - hex digit to active-low {g,f,e,d,c,b,a} segment patterns
//   hex_to_seg - lookup helper around SEG_LUT
// -----------------------------------------------------------------------------
package top_pkg;

    localparam int CNT_W  = 4;
    localparam int DATA_W = 16;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index is the hex value; entries are active-low gfedcba.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/top_if.sv
// -----------------------------------------------------------------------------
// top_if
// Shift-path bundle between the counter/display logic and the barrel shifter.
//   data   - word to be shifted
//   amount - shift distance, taken from the shift-amount counter
//   result - shifted word
// Modports:
//   master - owner of data/amount, consumer of result
//   slave  - the shifter: consumes data/amount, produces result
// -----------------------------------------------------------------------------
interface top_if;
    import top_pkg::*;

    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  amount;
    logic [DATA_W-1:0] result;

    modport master (output data, output amount, input result);
    modport slave  (input data, input amount, output result);

endinterface

// File: rtl/top_barrel_shifter.sv
// -----------------------------------------------------------------------------
// barrel_shifter
// Combinational 4-stage logarithmic left shifter on a 16-bit word.
// Stage k moves the word by 2**k positions when amount[k] is set.
// Ports (top_if.slave):
//   bus.data   in  16  word to shift
//   bus.amount in  4   shift distance
//   bus.result out 16  shifted word
// Configuration macro TOP_ROTATE_EN:
//   defined   - circular rotate left (bit 15 wraps into bit 0)
//   undefined - logical shift left with zero fill
// -----------------------------------------------------------------------------
module barrel_shifter
    import top_pkg::*;
(
    top_if.slave bus
);

    logic [DATA_W-1:0] w_acc;

    // NOTE: combinational logic uses blocking '=' so each stage sees the
    // previous stage's value within the same evaluation; w_acc is assigned
    // before any conditional use, so no latch is inferred.
    always_comb begin
        w_acc = bus.data;
        for (int k = 0; k < CNT_W; k++) begin
            if (bus.amount[k]) begin
`ifdef TOP_ROTATE_EN
                w_acc = (w_acc << (1 << k)) | (w_acc >> (DATA_W - (1 << k)));
`else
                w_acc = w_acc << (1 << k);
`endif
            end
        end
    end

    assign bus.result = w_acc;

endmodule

// File: rtl/top.sv
// -----------------------------------------------------------------------------
// top
// Loadable 4-bit shift counter paced by a clock divider; the 16-bit input word
// is shifted left by the counter value and shown as four hex digits on a
// multiplexed, active-low 8-digit seven-segment display.
// Parameters:
//   CLK  - system clocks per counter tick (>= 1)
//   SCAN - system clocks per display digit step (>= 1)
// Ports:
//   top_port_clk in  1   system clock (rising edge)
//   top_port_rst in  1   synchronous active-high reset of the whole block
//   top_clk_rst  in  1   synchronous active-high reset of the tick divider
//   top_load     in  1   level-sensitive load of the counter from top_input[3:0]
//   top_input    in  16  data word; low nibble is also the load value
//   top_port_ssd out 7   segments {g,f,e,d,c,b,a}, active-low, registered
//   top_port_an  out 8   digit enables, active-low, registered
// Configuration macro TOP_ROTATE_EN selects rotate (defined) or zero-fill
// shift (undefined) inside barrel_shifter.
// -----------------------------------------------------------------------------
module top
    import top_pkg::*;
#(
    parameter int CLK  = 100_000_000,
    parameter int SCAN = 100_000
) (
    input  logic              top_port_clk,
    input  logic              top_port_rst,
    input  logic              top_clk_rst,
    input  logic              top_load,
    input  logic [DATA_W-1:0] top_input,
    output logic [6:0]        top_port_ssd,
    output logic [7:0]        top_port_an
);

    localparam int DIV_W  = (CLK  > 1) ? $clog2(CLK)  : 1;
    localparam int SCAN_W = (SCAN > 1) ? $clog2(SCAN) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN - 1);

    logic [DIV_W-1:0]  r_div;
    logic [SCAN_W-1:0] r_scan;
    logic [1:0]        r_dig;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_an;
    logic [6:0]        r_ssd;

    logic              w_tick;
    logic [DATA_W-1:0] w_shifted;
    logic [3:0]        w_nibble;

    // A divider reset in the terminal cycle cancels that tick, so the next
    // increment is a full CLK period after the divider restart.
    assign w_tick = (r_div == DIV_LAST) && !top_clk_rst;

    // NOTE: reset here is synchronous and active-high, so it is tested inside
    // the clocked block rather than in the sensitivity list; sequential state
    // uses non-blocking '<=' so all flops update together at the edge.
    always_ff @(posedge top_port_clk) begin
        if (top_port_rst || top_clk_rst) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Load is level-sensitive and beats a coincident tick (the tick is lost).
    always_ff @(posedge top_port_clk) begin
        if (top_port_rst) begin
            r_cnt <= '0;
        end else if (top_load) begin
            r_cnt <= top_input[CNT_W-1:0];
        end else if (w_tick) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge top_port_clk) begin
        if (top_port_rst) begin
            r_scan <= '0;
            r_dig  <= '0;
        end else if (r_scan == SCAN_LAST) begin
            r_scan <= '0;
            r_dig  <= r_dig + 2'd1;
        end else begin
            r_scan <= r_scan + SCAN_W'(1);
        end
    end

    top_if u_shift_if ();

    assign u_shift_if.data   = top_input;
    assign u_shift_if.amount = r_cnt;
    assign w_shifted         = u_shift_if.result;

    barrel_shifter u_shifter (
        .bus (u_shift_if.slave)
    );

    assign w_nibble = w_shifted[{r_dig, 2'b00} +: 4];

    // Digits 4..7 are never driven, so an[7:4] stays high.
    always_ff @(posedge top_port_clk) begin
        if (top_port_rst) begin
            r_an  <= 8'hFF;
            r_ssd <= SEG_BLANK;
        end else begin
            r_an  <= ~(8'b1 << r_dig);
            r_ssd <= hex_to_seg(w_nibble);
        end
    end

    assign top_port_an  = r_an;
    assign top_port_ssd = r_ssd;

endmodule

// File: tb/tb_top.sv
// -----------------------------------------------------------------------------
// tb_top
// Three instances of top with different CLK/SCAN settings share one stimulus
// stream; each is compared every cycle against a behavioural model. The
// barrel shifter is also exercised on its own through a top_if instance.
// -----------------------------------------------------------------------------
module tb_top;

    localparam int NDUT = 3;
    localparam int CLKP  [NDUT] = '{5, 2, 1};
    localparam int SCANP [NDUT] = '{3, 1, 2};

    logic        clk = 1'b0;
    logic        rst;
    logic        crst;
    logic        load;
    logic [15:0] din;

    logic [NDUT-1:0][6:0] w_ssd;
    logic [NDUT-1:0][7:0] w_an;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_ref [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int         m_div  [NDUT];
    int         m_cnt  [NDUT];
    int         m_dig  [NDUT];
    int         m_scan [NDUT];
    logic [7:0] m_an   [NDUT];
    logic [6:0] m_ssd  [NDUT];

    always #5 clk = ~clk;

    top #(.CLK(5), .SCAN(3)) u_dut_a (
        .top_port_clk (clk),   .top_port_rst (rst),  .top_clk_rst (crst),
        .top_load     (load),  .top_input    (din),
        .top_port_ssd (w_ssd[0]), .top_port_an (w_an[0])
    );

    top #(.CLK(2), .SCAN(1)) u_dut_b (
        .top_port_clk (clk),   .top_port_rst (rst),  .top_clk_rst (crst),
        .top_load     (load),  .top_input    (din),
        .top_port_ssd (w_ssd[1]), .top_port_an (w_an[1])
    );

    top #(.CLK(1), .SCAN(2)) u_dut_c (
        .top_port_clk (clk),   .top_port_rst (rst),  .top_clk_rst (crst),
        .top_load     (load),  .top_input    (din),
        .top_port_ssd (w_ssd[2]), .top_port_an (w_an[2])
    );

    top_if u_if ();

    barrel_shifter u_bs (
        .bus (u_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Shift through a double-width word: the spilled high half is the part
    // that a rotate brings back in at the bottom.
    function automatic logic [15:0] ref_shift(input logic [15:0] d, input int c);
        logic [31:0] w;
        w = {16'b0, d} << c;
`ifdef TOP_ROTATE_EN
        return w[15:0] | w[31:16];
`else
        return w[15:0];
`endif
    endfunction

    task automatic model_update();
        logic [15:0] sh;
        bit          tick;
        for (int j = 0; j < NDUT; j++) begin
            if (rst) begin
                m_an[j]  = 8'hFF;
                m_ssd[j] = 7'h7F;
            end else begin
                sh       = ref_shift(din, m_cnt[j]);
                m_an[j]  = ~(8'd1 << m_dig[j]);
                m_ssd[j] = seg_ref[(sh >> (4 * m_dig[j])) & 16'hF];
            end
            tick = (m_div[j] == CLKP[j] - 1) && !crst;
            if (rst)       m_cnt[j] = 0;
            else if (load) m_cnt[j] = din % 16;
            else if (tick) m_cnt[j] = (m_cnt[j] + 1) % 16;
            if (rst || crst) m_div[j] = 0;
            else             m_div[j] = (m_div[j] + 1) % CLKP[j];
            if (rst) begin
                m_scan[j] = 0;
                m_dig[j]  = 0;
            end else if (m_scan[j] == SCANP[j] - 1) begin
                m_scan[j] = 0;
                m_dig[j]  = (m_dig[j] + 1) % 4;
            end else begin
                m_scan[j] = m_scan[j] + 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        for (int j = 0; j < NDUT; j++) begin
            check($sformatf("an%0d", j),  w_an[j],  m_an[j]);
            check($sformatf("ssd%0d", j), w_ssd[j], m_ssd[j]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        crst = 1'b0;
        load = 1'b0;
        din  = 16'h0008;

        // Stand-alone shifter: fixed cases, then random against the model.
        u_if.data = 16'h0008; u_if.amount = 4'd4;  #1;
        check("bs_amt4", u_if.result, 16'h0080);
        u_if.amount = 4'd8;  #1;
        check("bs_amt8", u_if.result, 16'h0800);
        u_if.amount = 4'd13; #1;
`ifdef TOP_ROTATE_EN
        check("bs_amt13", u_if.result, 16'h0001);
`else
        check("bs_amt13", u_if.result, 16'h0000);
`endif
        for (int i = 0; i < 40; i++) begin
            u_if.data   = 16'($urandom);
            u_if.amount = 4'($urandom_range(15, 0));
            #1;
            check("bs_rand", u_if.result, ref_shift(u_if.data, int'(u_if.amount)));
        end

        // Reset cycle (edge 0), then first displayed digit.
        step();
        check("rst_an",  w_an[1],  8'hFF);
        check("rst_ssd", w_ssd[1], 7'h7F);
        rst = 1'b0;
        step();
        check("first_an",  w_an[1],  8'hFE);
        check("first_ssd", w_ssd[1], 7'h00);

        // Counting: on the CLK=2 instance cnt reaches 4 at edge 8.
        repeat (8) step();
        check("cnt4_dig0_ssd", w_ssd[1], 7'h40);
        step();
        check("cnt4_dig1_an",  w_an[1],  8'hFD);
        check("cnt4_dig1_ssd", w_ssd[1], 7'h00);

        // Level load of 8 held for five cycles: shifted = 0x0800.
        load = 1'b1;
        repeat (5) step();
        check("load_dig2_an",  w_an[1],  8'hFB);
        check("load_dig2_ssd", w_ssd[1], 7'h00);

        // Load 13, then show the 0x0008 word shifted by 13 on digit 0.
        din = 16'h000D;
        step();
        load = 1'b0;
        din  = 16'h0008;
        step();
        check("wrap_an", w_an[1], 8'hFE);
`ifdef TOP_ROTATE_EN
        check("wrap_ssd", w_ssd[1], 7'h79);
`else
        check("wrap_ssd", w_ssd[1], 7'h40);
`endif
        repeat (12) step();

        // Divider reset in the terminal cycle of the CLK=5 instance.
        for (int i = 0; i < 10 && m_div[0] != CLKP[0] - 1; i++) step();
        check("div_sync", m_div[0], CLKP[0] - 1);
        crst = 1'b1;
        step();
        crst = 1'b0;
        repeat (12) step();

        // Random operation.
        for (int i = 0; i < 1500; i++) begin
            rst  = ($urandom_range(99, 0) < 1);
            crst = ($urandom_range(99, 0) < 4);
            load = ($urandom_range(99, 0) < 6);
            if ($urandom_range(9, 0) < 3) din = 16'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
